// File: rtl/mem_axil_master.sv
// Load/store unit to AXI4-Lite bridge: one outstanding byte/half/word access,
// with store lane packing and sign/zero extension of load data.
module mem_axil_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    state_t                r_state;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;

    logic w_aw_done;
    logic w_w_done;
    logic w_unused;

    // A channel is finished once its valid has dropped or is being accepted now.
    assign w_aw_done = !r_awvalid || awready;
    assign w_w_done  = !r_wvalid  || wready;
    assign w_unused  = &{1'b0, bresp[0], rresp[0]};

    function automatic logic [DATA_WIDTH-1:0] f_pack(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return DATA_WIDTH'(d[7:0]);
            SZ_HALF: return DATA_WIDTH'(d[15:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic [STRB_WIDTH-1:0] f_strb(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return STRB_WIDTH'(4'b0001);
            SZ_HALF: return STRB_WIDTH'(4'b0011);
            default: return STRB_WIDTH'(4'b1111);
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_extend(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] sz,
                                                       input logic uns);
        case (sz)
            SZ_BYTE: return {{(DATA_WIDTH-8){d[7] & ~uns}}, d[7:0]};
            SZ_HALF: return {{(DATA_WIDTH-16){d[15] & ~uns}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        if (req_size == SZ_ILLEGAL) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else if (req_write) begin
                            r_awaddr  <= req_addr;
                            r_wdata   <= f_pack(req_wdata, req_size);
                            r_wstrb   <= f_strb(req_size);
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_araddr  <= req_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_awvalid && awready) r_awvalid <= 1'b0;
                    if (r_wvalid && wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= bresp[1];
                        r_rsp_rdata <= '0;
                        r_state     <= S_RESP;
                    end
                end
                S_RADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= rresp[1];
                        r_rsp_rdata <= rresp[1] ? '0 : f_extend(rdata, r_size, r_unsigned);
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign awaddr    = r_awaddr;
    assign awprot    = 3'b000;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign araddr    = r_araddr;
    assign arprot    = 3'b000;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;

endmodule

// File: doc/mem_axil_master.md
# mem_axil_master

Bridge between the core's load/store unit and the AXI4-Lite memory bus: accepts one byte/half/word load or store request at a time, drives a single AXI4-Lite master transaction, and returns load data sign- or zero-extended. Sits directly upstream of the AXI4-Lite RAM slave; its AXI ports connect one-to-one to the slave's ports. Strictly one outstanding transaction; no buffering beyond the active request.

## Interface
- DATA_WIDTH, 32: AXI data width; only 32 supported.
- ADDR_WIDTH, 16: byte-address width.
- STRB_WIDTH, DATA_WIDTH/8: write-strobe width.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge idle, request accepted on valid&&ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on valid&&ready.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  bus error or illegal size.
- awaddr, awprot, awvalid / awready: out ADDR_WIDTH, out 3, out 1 / in 1.
- wdata, wstrb, wvalid / wready: out DATA_WIDTH, out STRB_WIDTH, out 1 / in 1.
- bresp, bvalid / bready: in 2, in 1 / out 1.
- araddr, arprot, arvalid / arready: out ADDR_WIDTH, out 3, out 1 / in 1.
- rdata, rresp, rvalid / rready: in DATA_WIDTH, in 2, in 1 / out 1.

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE: req_ready=1. On accept, latch write/addr/wdata/size/unsigned. size==3 -> RESP with rsp_err=1, rsp_rdata=0, no bus activity. Store -> WRITE. Load -> RADDR.
- WRITE: awvalid and wvalid asserted together on entry; each deasserts independently after its own handshake (aw_done, w_done flags); both done -> WRESP. Simultaneous or either order accepted.
- Store encoding: awaddr=latched addr unmodified (slaves address bytes; lane 0 = byte at awaddr). wdata = req_wdata low bytes in low lanes, unused lanes 0. wstrb: size0 4'b0001, size1 4'b0011, size2 4'b1111.
- WRESP: bready=1; on bvalid -> RESP, rsp_err=bresp[1], rsp_rdata=0.
- RADDR: arvalid=1, araddr=latched addr; on arready -> RDATA.
- RDATA: rready=1; on rvalid capture: size0 rdata[7:0], size1 rdata[15:0], size2 rdata[31:0], extended per req_unsigned -> RESP. rresp[1]=1 -> rsp_err=1, rsp_rdata=0.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready -> IDLE.
- awprot=arprot=3'b000 always.
- Misaligned addresses allowed, passed through unchanged; no alignment check.
- AXI rules: address/data/valid held stable while valid and not ready; valids never depend combinationally on readies.

## Timing
- Reset: state IDLE; req_ready=0 while rst high, 1 first cycle after; awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err all 0; awaddr, wdata, wstrb, araddr, rsp_rdata 0.
- Reset mid-transaction: abandons immediately, all valids/readies 0 next cycle; slave shares rst.
- Accept at edge T; AXI valids asserted from T+1 (registered).
- With zero-wait slave (awready/wready/arready high in idle, b/r one cycle after handshake): store and load both rsp_valid at T+3.
- Illegal size: rsp_valid at T+1.
- req_ready=0 from T+1 until cycle after rsp handshake; next request accepted earliest in the cycle after rsp_valid&&rsp_ready.
- rsp_valid held indefinitely while rsp_ready=0; no new AXI traffic meanwhile.

## Test plan
- Word store addr 0x0010 data 0xDEADBEEF, zero-wait slave -> awaddr 0x0010, wstrb 4'b1111, rsp_valid at T+3, rsp_err 0; then word load 0x0010 -> rsp_rdata 0xDEADBEEF.
- Byte store addr 0x0021 data 0x000000F0 -> wstrb 4'b0001, wdata 0x000000F0; signed byte load 0x0021 -> 0xFFFFFFF0; unsigned -> 0x000000F0.
- Half load from slave returning rdata 0x12348001: signed -> 0xFFFF8001; unsigned -> 0x00008001.
- Slave stalls wready 3 cycles, awready immediate -> awvalid drops after 1 cycle, wvalid held with stable wdata/wstrb, bready only after both done; bresp 2'b10 -> rsp_err 1, rsp_rdata 0.
- req_size 3 -> rsp_valid at T+1, rsp_err 1, no awvalid/arvalid ever asserted; rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready 0.
- rst asserted while in RDATA -> next cycle arvalid/rready/rsp_valid 0, req_ready 1 after release; fresh load completes normally.
